// File: rtl/vga_timing_gen.sv
// Raster timing source for a 640x480@60 display: pixel/line counters, visible flag,
// line/frame strobes, a frame counter, and hs/vs delayed to match a registered RGB stage.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1023");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
  end

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]          r_draw_x;
  logic [9:0]          r_draw_y;
  logic                r_blank;
  logic                r_line_start;
  logic                r_frame_start;
  logic [7:0]          r_frame_count;
  logic [PIPE_DELAY:0] r_hs_pipe;
  logic [PIPE_DELAY:0] r_vs_pipe;

  logic [9:0] w_next_x;
  logic [9:0] w_next_y;
  logic       w_x_wrap;
  logic       w_frame_wrap;
  logic       w_hs_raw;
  logic       w_vs_raw;

  // Everything registered is decoded from the next count, so each output lines up
  // with the DrawX/DrawY value it describes on the same clock.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_next_x = r_draw_x + 10'd1;
    w_next_y = r_draw_y;
    w_x_wrap = (r_draw_x >= H_MAX);
    if (w_x_wrap) begin
      w_next_x = '0;
      w_next_y = (r_draw_y >= V_MAX) ? 10'd0 : r_draw_y + 10'd1;
    end
    w_frame_wrap = (w_next_x == 10'd0) && (w_next_y == 10'd0);
    w_hs_raw = (w_next_x >= H_SYNC_BEG && w_next_x < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    w_vs_raw = (w_next_y >= V_SYNC_BEG && w_next_y < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
      r_hs_pipe     <= {(PIPE_DELAY + 1){~SYNC_POL}};
      r_vs_pipe     <= {(PIPE_DELAY + 1){~SYNC_POL}};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_draw_x      <= w_next_x;
      r_draw_y      <= w_next_y;
      r_blank       <= (w_next_x < H_VIS) && (w_next_y < V_VIS);
      r_line_start  <= (w_next_x == 10'd0);
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
      r_hs_pipe[0] <= w_hs_raw;
      r_vs_pipe[0] <= w_vs_raw;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
    end
  end

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign hs          = r_hs_pipe[PIPE_DELAY];
  assign vs          = r_vs_pipe[PIPE_DELAY];

endmodule
